// File: rtl/spi_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_sequencer_pkg
// Brief    : Opcodes, instruction field positions and FSM states shared by
//            the display-link sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package spi_sequencer_pkg;

   localparam logic [1:0] OP_CMD   = 2'b00;
   localparam logic [1:0] OP_DATA  = 2'b01;
   localparam logic [1:0] OP_DELAY = 2'b10;
   localparam logic [1:0] OP_END   = 2'b11;

   localparam int OPC_HI = 9;
   localparam int OPC_LO = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_WAIT   = 3'd2,
      ST_DECODE = 3'd3,
      ST_SHIFT  = 3'd4,
      ST_DELAY  = 3'd5
   } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_byte_shifter.sv
`default_nettype none
// ============================================================================
// Module   : spi_byte_shifter
// Brief    : MSB-first byte serializer advanced by serial-clock falling-edge
//            strobes; flags the edge that closes the byte.
// Revision : 1.0 - initial release
// ============================================================================
module spi_byte_shifter #(
   parameter int DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic [DATA_BITS-1:0] load_data,
   input  logic                 neg_edge,
   output logic                 byte_done,
   output logic                 mosi,
   output logic                 sclk_gate
);

   localparam int c_cnt_w = $clog2(DATA_BITS + 1);

   logic [DATA_BITS-1:0] r_sr;
   logic [c_cnt_w-1:0]   r_cnt;
   logic                 r_active;

   // The falling edge after the last bit only closes the gate.
   assign byte_done = r_active && neg_edge && (r_cnt == c_cnt_w'(DATA_BITS));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sr      <= '0;
         r_cnt     <= '0;
         r_active  <= 1'b0;
         mosi      <= 1'b0;
         sclk_gate <= 1'b0;
      end else if (load) begin
         r_sr     <= load_data;
         r_cnt    <= '0;
         r_active <= 1'b1;
      end else if (r_active && neg_edge) begin
         if (byte_done) begin
            sclk_gate <= 1'b0;
            r_active  <= 1'b0;
         end else begin
            mosi      <= r_sr[DATA_BITS-1];
            r_sr      <= {r_sr[DATA_BITS-2:0], 1'b0};
            r_cnt     <= r_cnt + c_cnt_w'(1);
            sclk_gate <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/spi_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : spi_sequencer
// Brief    : Fetches and executes CMD/DATA/DELAY/END instruction words,
//            driving MOSI, CS, D/C and the SCLK gate of the display link.
// Revision : 1.0 - initial release
// ============================================================================
module spi_sequencer
   import spi_sequencer_pkg::*;
#(
   parameter int MEM_ADDR_WIDTH = 16,
   parameter int MEM_BITS       = 10,
   parameter int DATA_BITS      = 8,
   parameter int DELAY_UNIT     = 1000,
   parameter int START_ADDR     = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      sclkPosEdge,
   input  logic                      sclkNegEdge,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic                      wrapErr,
   output logic [MEM_ADDR_WIDTH-1:0] memAddr,
   input  logic [MEM_BITS-1:0]       memData,
   output logic                      mosi,
   output logic                      cs,
   output logic                      dc,
   output logic                      sclkGate
);

   localparam int c_delay_w = $clog2(((1 << DATA_BITS) - 1) * DELAY_UNIT + 1);
   localparam logic [c_delay_w-1:0] c_delay_unit = c_delay_w'(DELAY_UNIT);

   state_t                 r_state;
   state_t                 w_next;
   logic [MEM_BITS-1:0]    r_instr;
   logic                   r_target_dc;
   logic [c_delay_w-1:0]   r_delay;
   logic [1:0]             w_opc;
   logic [c_delay_w-1:0]   w_delay_load;
   logic                   w_accept;
   logic                   w_load;
   logic                   w_addr_inc;
   logic                   w_byte_done;

   assign w_opc        = r_instr[OPC_HI:OPC_LO];
   assign w_delay_load = c_delay_w'(r_instr[DATA_BITS-1:0]) * c_delay_unit;

   spi_byte_shifter #(
      .DATA_BITS (DATA_BITS)
   ) u_shifter (
      .clk       (clk),
      .reset     (reset),
      .load      (w_load),
      .load_data (r_instr[DATA_BITS-1:0]),
      .neg_edge  (sclkNegEdge),
      .byte_done (w_byte_done),
      .mosi      (mosi),
      .sclk_gate (sclkGate)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // A start arriving in the done cycle is dropped, not queued.
   always_comb begin
      w_next     = r_state;
      w_accept   = 1'b0;
      w_load     = 1'b0;
      w_addr_inc = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start && !done) begin
               w_accept = 1'b1;
               w_next   = ST_FETCH;
            end
         end
         ST_FETCH: w_next = ST_WAIT;
         ST_WAIT:  w_next = ST_DECODE;
         ST_DECODE: begin
            case (w_opc)
               OP_CMD, OP_DATA: begin
                  w_load = 1'b1;
                  w_next = ST_SHIFT;
               end
               OP_DELAY: w_next = ST_DELAY;
               default:  w_next = ST_IDLE;
            endcase
         end
         ST_SHIFT: begin
            if (w_byte_done) begin
               w_addr_inc = 1'b1;
               w_next     = ST_FETCH;
            end
         end
         ST_DELAY: begin
            if (r_delay == '0) begin
               w_addr_inc = 1'b1;
               w_next     = ST_FETCH;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         memAddr     <= MEM_ADDR_WIDTH'(START_ADDR);
         busy        <= 1'b0;
         done        <= 1'b0;
         wrapErr     <= 1'b0;
         cs          <= 1'b1;
         dc          <= 1'b0;
         r_instr     <= '0;
         r_target_dc <= 1'b0;
         r_delay     <= '0;
      end else begin
         done <= 1'b0;
         if (w_accept) begin
            memAddr <= MEM_ADDR_WIDTH'(START_ADDR);
            busy    <= 1'b1;
            wrapErr <= 1'b0;
         end
         if (r_state == ST_WAIT) r_instr <= memData;
         if (r_state == ST_DECODE) begin
            case (w_opc)
               OP_CMD, OP_DATA: r_target_dc <= w_opc[0];
               OP_DELAY: begin
                  cs      <= 1'b1;
                  r_delay <= w_delay_load;
               end
               default: begin
                  cs   <= 1'b1;
                  dc   <= 1'b0;
                  busy <= 1'b0;
                  done <= 1'b1;
               end
            endcase
         end
         // CS/DC settle on the first falling edge of a byte and hold after it.
         if ((r_state == ST_SHIFT) && sclkNegEdge && !w_byte_done) begin
            cs <= 1'b0;
            dc <= r_target_dc;
         end
         if ((r_state == ST_DELAY) && (r_delay != '0) && sclkPosEdge && !sclkNegEdge)
            r_delay <= r_delay - c_delay_w'(1);
         if (w_addr_inc) begin
            memAddr <= memAddr + MEM_ADDR_WIDTH'(1);
            if (&memAddr) wrapErr <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spi_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_sequencer
// Brief    : Randomized self-checking bench for spi_sequencer against a
//            program-walking reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       sclkPosEdge;
   logic       sclkNegEdge;
   logic       start;
   logic       busy;
   logic       done;
   logic       wrapErr;
   logic [3:0] memAddr;
   logic [9:0] memData;
   logic       mosi;
   logic       cs;
   logic       dc;
   logic       sclkGate;

   logic [9:0] mem [0:15];
   logic       sclk_en;
   logic       mon_clr;

   int checks   = 0;
   int failures = 0;

   spi_sequencer #(
      .MEM_ADDR_WIDTH (4),
      .MEM_BITS       (10),
      .DATA_BITS      (8),
      .DELAY_UNIT     (4),
      .START_ADDR     (0)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .sclkPosEdge (sclkPosEdge),
      .sclkNegEdge (sclkNegEdge),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .wrapErr     (wrapErr),
      .memAddr     (memAddr),
      .memData     (memData),
      .mosi        (mosi),
      .cs          (cs),
      .dc          (dc),
      .sclkGate    (sclkGate)
   );

   always #5 clk = ~clk;

   always @(posedge clk) memData <= mem[memAddr];

   // Serial-clock strobes: alternating falling/rising, random 1..3 clk gaps.
   initial begin
      int  gap;
      bit  phase;
      gap = 1;
      phase = 1'b0;
      sclkPosEdge = 1'b0;
      sclkNegEdge = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         sclkPosEdge = 1'b0;
         sclkNegEdge = 1'b0;
         if (sclk_en) begin
            if (gap > 0) gap--;
            else begin
               if (phase) sclkPosEdge = 1'b1;
               else       sclkNegEdge = 1'b1;
               phase = ~phase;
               gap   = $urandom_range(1, 3);
            end
         end
      end
   end

   // Link monitor: assembles bytes seen on gated rising edges.
   logic [8:0] mon_bytes [0:63];
   logic [7:0] mon_sr;
   logic       mon_prev_cs;
   int         mon_n, mon_bits, mon_rises, mon_cs_err;

   always @(negedge clk) begin
      if (!reset || mon_clr) begin
         mon_n       <= 0;
         mon_bits    <= 0;
         mon_rises   <= 0;
         mon_cs_err  <= 0;
         mon_prev_cs <= 1'b1;
         mon_sr      <= '0;
      end else begin
         mon_prev_cs <= cs;
         if (cs && !mon_prev_cs) mon_rises <= mon_rises + 1;
         if (sclkPosEdge && sclkGate) begin
            if (cs !== 1'b0) mon_cs_err <= mon_cs_err + 1;
            if (mon_bits == 7) begin
               mon_bytes[mon_n] <= {dc, mon_sr[6:0], mosi};
               mon_n            <= mon_n + 1;
               mon_bits         <= 0;
            end else begin
               mon_sr   <= {mon_sr[6:0], mosi};
               mon_bits <= mon_bits + 1;
            end
         end
      end
   end

   // Reference model: walk the program from address 0 to the first END.
   logic [8:0] exp_q [$];
   int         exp_rises, exp_end;

   task automatic run_model();
      bit low;
      low = 1'b0;
      exp_q.delete();
      exp_rises = 0;
      exp_end   = -1;
      for (int a = 0; a < 16 && exp_end < 0; a++) begin
         case (mem[a][9:8])
            2'b00, 2'b01: begin
               exp_q.push_back(mem[a][8:0]);
               low = 1'b1;
            end
            2'b10: begin
               if (low) exp_rises++;
               low = 1'b0;
            end
            default: begin
               if (low) exp_rises++;
               exp_end = a;
            end
         endcase
      end
   endtask

   task automatic mon_clear();
      mon_clr = 1'b1;
      @(negedge clk);
      #1 mon_clr = 1'b0;
   endtask

   task automatic start_and_wait(input int budget, output bit ok, output logic busy_after);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      busy_after = busy;
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (done === 1'b1) ok = 1'b1;
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({cs, dc, mosi, sclkGate, busy, done, wrapErr} !== 7'b1000000) begin
         failures++;
         $display("FAIL reset_outputs got=%b exp=1000000", {cs, dc, mosi, sclkGate, busy, done, wrapErr});
      end
      checks++;
      if (memAddr !== 4'd0) begin
         failures++;
         $display("FAIL reset_memaddr got=%0d exp=0", memAddr);
      end
      mem[0] = 10'h1AE;
      mem[1] = 10'h3FF;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int i = 0; i < 400 && mon_bits != 3; i++) @(negedge clk);
      checks++;
      if (mon_bits != 3) begin
         failures++;
         $display("FAIL reset_reach_bit3 got=%0d exp=3", mon_bits);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({cs, dc, mosi, sclkGate, busy, done, wrapErr} !== 7'b1000000) begin
         failures++;
         $display("FAIL reset_async_outputs got=%b exp=1000000", {cs, dc, mosi, sclkGate, busy, done, wrapErr});
      end
      checks++;
      if (memAddr !== 4'd0) begin
         failures++;
         $display("FAIL reset_async_memaddr got=%0d exp=0", memAddr);
      end
      @(negedge clk) reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_byte();
      bit   ok;
      logic b;
      mem[0] = 10'h0AE;
      mem[1] = 10'h3FF;
      mon_clear();
      start_and_wait(2000, ok, b);
      checks++;
      if (!ok || b !== 1'b1) begin
         failures++;
         $display("FAIL single_done_busy got_done=%0b got_busy=%b exp=1,1", ok, b);
      end
      checks++;
      if (mon_n != 1 || mon_bytes[0] !== 9'h0AE) begin
         failures++;
         $display("FAIL single_byte got_n=%0d got=%h exp_n=1 exp=0ae", mon_n, mon_bytes[0]);
      end
      checks++;
      if (mon_cs_err != 0 || mon_rises != 1) begin
         failures++;
         $display("FAIL single_cs got_err=%0d got_rises=%0d exp=0,1", mon_cs_err, mon_rises);
      end
      checks++;
      if ({memAddr, cs, sclkGate, busy, dc} !== {4'd1, 4'b1000}) begin
         failures++;
         $display("FAIL single_final got=%b exp=%b", {memAddr, cs, sclkGate, busy, dc}, {4'd1, 4'b1000});
      end
   endtask

   task automatic test_cmd_data();
      bit   ok;
      logic b;
      mem[0] = 10'h055;
      mem[1] = 10'h1A5;
      mem[2] = 10'h3FF;
      mon_clear();
      start_and_wait(3000, ok, b);
      checks++;
      if (!ok || mon_n != 2 || mon_bytes[0] !== 9'h055 || mon_bytes[1] !== 9'h1A5) begin
         failures++;
         $display("FAIL cmd_data_bytes got_done=%0b n=%0d b0=%h b1=%h exp=1,2,055,1a5", ok, mon_n, mon_bytes[0], mon_bytes[1]);
      end
      checks++;
      if (mon_rises != 1 || mon_cs_err != 0) begin
         failures++;
         $display("FAIL cmd_data_cs_low got_rises=%0d got_err=%0d exp=1,0", mon_rises, mon_cs_err);
      end
   endtask

   task automatic test_delay();
      int pos, cs_bad, n1;
      bit ok;
      mem[0] = 10'h203;
      mem[1] = 10'h200;
      mem[2] = 10'h3FF;
      @(negedge clk) sclk_en = 1'b0;
      repeat (2) @(negedge clk);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (cs !== 1'b1 || busy !== 1'b1 || memAddr !== 4'd0) begin
         failures++;
         $display("FAIL delay_enter got_cs=%b busy=%b addr=%0d exp=1,1,0", cs, busy, memAddr);
      end
      sclk_en = 1'b1;
      pos = 0;
      cs_bad = 0;
      for (int i = 0; i < 500 && memAddr != 4'd1; i++) begin
         @(negedge clk);
         if (memAddr != 4'd1 && sclkPosEdge) pos++;
         if (cs !== 1'b1) cs_bad++;
      end
      checks++;
      if (pos != 12 || cs_bad != 0) begin
         failures++;
         $display("FAIL delay_posedges got=%0d cs_bad=%0d exp=12,0", pos, cs_bad);
      end
      n1 = 0;
      for (int i = 0; i < 50 && memAddr == 4'd1; i++) begin
         n1++;
         @(negedge clk);
      end
      checks++;
      if (n1 != 4 || memAddr !== 4'd2) begin
         failures++;
         $display("FAIL delay_zero got_cycles=%0d addr=%0d exp=4,2", n1, memAddr);
      end
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (done === 1'b1) ok = 1'b1;
      end
      @(negedge clk);
      checks++;
      if (!ok || busy !== 1'b0 || cs !== 1'b1) begin
         failures++;
         $display("FAIL delay_end got_done=%0b busy=%b cs=%b exp=1,0,1", ok, busy, cs);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      mem[0] = 10'h3FF;
      @(negedge clk) start = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (done === 1'b1) ok = 1'b1;
      end
      @(negedge clk);
      checks++;
      if (!ok || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL b2b_start_in_done got_done=%0b busy=%b done=%b exp=1,0,0", ok, busy, done);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL b2b_restart got_busy=%b exp=1", busy);
      end
      start = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (done === 1'b1) ok = 1'b1;
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL b2b_second_done got=0 exp=1");
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_wrap();
      bit         ok;
      logic       b;
      logic [3:0] addr_at_wrap;
      for (int a = 0; a < 16; a++) mem[a] = 10'h200;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      ok = 1'b0;
      addr_at_wrap = 4'hx;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (wrapErr === 1'b1) begin
            ok = 1'b1;
            addr_at_wrap = memAddr;
         end
      end
      checks++;
      if (!ok || addr_at_wrap !== 4'd0) begin
         failures++;
         $display("FAIL wrap_set got_wrap=%0b addr=%0d exp=1,0", ok, addr_at_wrap);
      end
      mem[5] = 10'h3FF;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      @(negedge clk);
      checks++;
      if (wrapErr !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL wrap_start_ignored got_wrap=%b busy=%b exp=1,1", wrapErr, busy);
      end
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (done === 1'b1) ok = 1'b1;
      end
      @(negedge clk);
      checks++;
      if (!ok || memAddr !== 4'd5 || wrapErr !== 1'b1) begin
         failures++;
         $display("FAIL wrap_sticky got_done=%0b addr=%0d wrap=%b exp=1,5,1", ok, memAddr, wrapErr);
      end
      start_and_wait(200, ok, b);
      checks++;
      if (!ok || wrapErr !== 1'b0 || memAddr !== 4'd5) begin
         failures++;
         $display("FAIL wrap_cleared_by_start got_done=%0b wrap=%b addr=%0d exp=1,0,5", ok, wrapErr, memAddr);
      end
      mem[0] = 10'h3FF;
      @(negedge clk) reset = 1'b0;
      @(negedge clk) reset = 1'b1;
      start_and_wait(100, ok, b);
      checks++;
      if (!ok || wrapErr !== 1'b0 || memAddr !== 4'd0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL wrap_after_reset got_done=%0b wrap=%b addr=%0d busy=%b exp=1,0,0,0", ok, wrapErr, memAddr, busy);
      end
   endtask

   task automatic test_random();
      bit   ok;
      logic b;
      int   n;
      for (int it = 0; it < 12; it++) begin
         n = $urandom_range(1, 8);
         for (int a = 0; a < 16; a++) mem[a] = 10'($urandom);
         for (int a = 0; a < n; a++) begin
            case ($urandom_range(0, 2))
               0:       mem[a] = {2'b00, 8'($urandom)};
               1:       mem[a] = {2'b01, 8'($urandom)};
               default: mem[a] = {2'b10, 8'($urandom_range(0, 2))};
            endcase
         end
         mem[n] = 10'h3FF;
         run_model();
         mon_clear();
         start_and_wait(4000, ok, b);
         checks++;
         if (!ok || mon_n != exp_q.size()) begin
            failures++;
            $display("FAIL random_count it=%0d got_done=%0b got_n=%0d exp_n=%0d", it, ok, mon_n, exp_q.size());
         end
         for (int k = 0; k < exp_q.size() && k < mon_n; k++) begin
            checks++;
            if (mon_bytes[k] !== exp_q[k]) begin
               failures++;
               $display("FAIL random_byte it=%0d k=%0d got=%h exp=%h", it, k, mon_bytes[k], exp_q[k]);
            end
         end
         checks++;
         if (mon_rises != exp_rises || mon_cs_err != 0 || memAddr !== 4'(exp_end) || wrapErr !== 1'b0) begin
            failures++;
            $display("FAIL random_ctrl it=%0d rises=%0d/%0d cs_err=%0d addr=%0d/%0d wrap=%b",
                     it, mon_rises, exp_rises, mon_cs_err, memAddr, exp_end, wrapErr);
         end
      end
   endtask

   initial begin
      reset   = 1'b0;
      start   = 1'b0;
      sclk_en = 1'b1;
      mon_clr = 1'b0;
      for (int a = 0; a < 16; a++) mem[a] = 10'h3FF;
      test_reset();
      test_single_byte();
      test_cmd_data();
      test_delay();
      test_back_to_back();
      test_wrap();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/spi_sequencer.md
Name: spi_sequencer

Overview:
Controller for the serial display link. It fetches 10-bit instruction words from program memory and decodes each one as command byte, data byte, delay or end. Byte instructions are serialized through an internal shifter, and the block drives MOSI, chip select, data/command and an SCLK gate. It replaces the separate program counter, FSM and delay counter with one start/busy/done-handshaked block between memory and the GPIO pins.

Parameters:
memAddrWidth, 16, program memory address width
memBits, 10, instruction word width: opcode [9:8], payload [7:0]
dataBits, 8, serialized byte width
delayUnit, 1000, sclkPosEdge strobes per delay payload count
startAddr, 0, first instruction address on each start

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
sclkPosEdge  input  1  one-clk strobe, serial clock rising edge
sclkNegEdge  input  1  one-clk strobe, serial clock falling edge
start  input  1  begin program at startAddr; sampled only in IDLE
busy  output  1  high from accepted start until END decoded
done  output  1  one-clk pulse when END executes
wrapErr  output  1  sticky; memAddr wrapped past all-ones; cleared on accepted start
memAddr  output  memAddrWidth  instruction address
memData  input  memBits  instruction word, valid one clk after memAddr (synchronous read)
mosi  output  1  serial data, MSB first
cs  output  1  chip select, active low
dc  output  1  0 = command, 1 = data
sclkGate  output  1  high while a byte is on the wire; enables SCLK downstream

Behaviour:
- Reset (reset=0, async):
  - State IDLE; memAddr=startAddr.
  - cs=1; dc=0; mosi=0; sclkGate=0; busy=0; done=0; wrapErr=0.
  - Reset asserted mid-byte or mid-delay takes effect immediately; no partial byte completes.
- States: IDLE, FETCH, WAIT, DECODE, SHIFT, DELAY.
- IDLE:
  - start=1 → memAddr<=startAddr, busy<=1, wrapErr<=0, go to FETCH.
  - start while busy=1 is ignored.
- FETCH → WAIT → DECODE. memData is captured at the end of WAIT (1-cycle read latency).
- DECODE on memData[9:8]:
  - 00 CMD / 01 DATA: load shifter with [7:0], latch target dc = opcode[0], go to SHIFT.
  - 10 DELAY: cs<=1, delay count <= payload*delayUnit, go to DELAY. A zero product advances next clk.
  - 11 END: cs<=1, dc<=0, busy<=0, done=1 for one clk, go to IDLE. memAddr holds at the END address.
- SHIFT:
  - Acts only on sclkNegEdge strobes.
  - Negedge 0: cs<=0, dc<=target, mosi<=bit7, sclkGate<=1.
  - Negedge k (1..7): mosi<=bit(7-k).
  - Negedge 8: sclkGate<=0, memAddr<=memAddr+1, go to FETCH.
  - cs stays low across back-to-back byte instructions; it rises only on DELAY or END.
- DELAY:
  - Decrements once per sclkPosEdge.
  - At zero: memAddr<=memAddr+1, go to FETCH.
- Address wrap: increment from all-ones gives 0, sets wrapErr, and execution continues.
- sclkPosEdge and sclkNegEdge never coincide. If both are seen, the negedge action wins and the posedge is dropped.
- start in the same clk as done is ignored; a new start is accepted from the following IDLE cycle.
- Delay counter width is ceil(log2(255*delayUnit+1)); the multiply is a constant-parameter product.

Decomposition:
- Shared package: opcode constants (OP_CMD=2'b00, OP_DATA=2'b01, OP_DELAY=2'b10, OP_END=2'b11), state encodings, field positions OPC_HI=9/OPC_LO=8.
- One sub-module: spi_byte_shifter (load, sclkNegEdge-driven shift, bit counter, byteDone pulse, mosi).

Test Plan:
1. Reset low for 3 clks, then high → cs=1, dc=0, mosi=0, sclkGate=0, busy=0, done=0, memAddr=0. Pulse reset low mid-SHIFT at bit 3 → same values immediately, without waiting for a clock edge.
2. Memory {0:0x0AE, 1:0x3FF}, start pulse:
   - busy=1; cs falls on the first sclkNegEdge; dc=0.
   - mosi at the 8 gated sclkPosEdges = 1,0,1,0,1,1,1,0.
   - Then sclkGate=0, cs=1, done pulse, memAddr=1, busy=0.
3. Memory {0:0x055, 1:0x1A5, 2:0x3FF}:
   - Command 0x55 with dc=0, then data 0xA5 with dc=1.
   - cs stays low between the two bytes.
4. delayUnit=4, memory {0:0x203, 1:0x200, 2:0x3FF}:
   - cs=1 during the delay; exactly 12 sclkPosEdges elapse before memAddr=1.
   - 0x200 advances one clk after decode; then done.
5. memAddrWidth=4, all 16 words 0x200:
   - After address 15, memAddr=0 and wrapErr=1.
   - start pulses during busy have no effect.
   - Write 0x3FF to address 0, then reset → a new start clears wrapErr and ends with done.
